// File: rtl/snn_pkg.sv
// Shared constants and types for the rate-coded spike encoder.
package snn_pkg;

  localparam int N_CH   = 4;
  localparam int INT_W  = 4;
  localparam int STEPS  = 16;  // 2**INT_W, so spike count equals intensity
  localparam int STEP_W = $clog2(STEPS);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef logic [INT_W-1:0] nibble_t;
  typedef nibble_t [N_CH-1:0] frame_t;

endpackage

// File: rtl/snn_spike_encoder_if.sv
// Configuration and frame-stream handshake bundle for snn_spike_encoder.
interface snn_spike_encoder_if;
  import snn_pkg::*;

  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [N_CH*INT_W-1:0]   cfg_intensity;
  logic                    abort;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_CH*INT_W-1:0]   out_frame;
  logic                    out_last;
  logic                    busy;

  modport master (
    output cfg_valid, cfg_intensity, abort, out_ready,
    input  cfg_ready, out_valid, out_frame, out_last, busy
  );

  modport slave (
    input  cfg_valid, cfg_intensity, abort, out_ready,
    output cfg_ready, out_valid, out_frame, out_last, busy
  );

endinterface

// File: rtl/snn_phase_acc.sv
// One channel's phase accumulator: spikes on carry-out of A + I.
// Build option SNN_ENC_BINARY_SPIKE_EN: a spike emits 1 instead of the intensity.
module snn_phase_acc
  import snn_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_load,
  input  logic    i_clear,
  input  logic    i_advance,
  input  logic    i_run,
  input  nibble_t i_intensity,
  output nibble_t o_nibble
);

  nibble_t          r_int;
  nibble_t          r_acc;
  logic [INT_W:0]   w_sum;
  logic             w_spike;
  nibble_t          w_spike_val;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_int};
  assign w_spike = w_sum[INT_W];

`ifdef SNN_ENC_BINARY_SPIKE_EN
  assign w_spike_val = nibble_t'(1);
`else
  assign w_spike_val = r_int;
`endif

  assign o_nibble = (i_run && w_spike) ? w_spike_val : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int <= '0;
      r_acc <= '0;
    end else begin
      if (i_load) r_int <= i_intensity;
      if (i_clear)        r_acc <= '0;
      else if (i_advance) r_acc <= w_sum[INT_W-1:0];
    end
  end

endmodule

// File: rtl/snn_spike_encoder.sv
// Rate-coded spike encoder: latches N_CH intensities and emits STEPS frames.
// Build option SNN_ENC_BINARY_SPIKE_EN selects unit-valued spike nibbles.
module snn_spike_encoder
  import snn_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  snn_spike_encoder_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [STEP_W-1:0] r_step;
  logic              w_run;
  logic              w_accept;
  logic              w_last;
  logic              w_xfer;
  logic              w_clear;
  logic              w_advance;
  logic              w_cfg_ready;
  logic              w_out_valid;
  frame_t            w_frame;

  assign w_run     = (r_state == RUN);
  assign w_accept  = bus.cfg_valid && w_cfg_ready;
  assign w_last    = w_run && (r_step == STEP_W'(STEPS-1));
  assign w_xfer    = w_out_valid && bus.out_ready;
  // abort wins over a simultaneous transfer, which is then discarded
  assign w_clear   = w_accept || (w_run && bus.abort);
  assign w_advance = w_xfer && !bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cfg_ready = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_cfg_ready = 1'b1;
        if (bus.cfg_valid) w_state_nxt = RUN;
      end
      RUN: begin
        w_out_valid = 1'b1;
        if (bus.abort)                          w_state_nxt = IDLE;
        else if (bus.out_ready && w_last)       w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_step <= '0;
    else if (w_clear)   r_step <= '0;
    else if (w_advance) r_step <= r_step + STEP_W'(1);
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    snn_phase_acc u_acc (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_accept),
      .i_clear     (w_clear),
      .i_advance   (w_advance),
      .i_run       (w_run),
      .i_intensity (bus.cfg_intensity[c*INT_W +: INT_W]),
      .o_nibble    (w_frame[c])
    );
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_run;
  assign bus.out_last  = w_last;
  assign bus.out_frame = w_frame;

endmodule

// File: tb/tb_snn_spike_encoder.sv
// Self-checking bench for snn_spike_encoder: vector table, corner sequences, random windows.
module tb_snn_spike_encoder;
  import snn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  snn_spike_encoder_if u_if ();

  snn_spike_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] vec;
    int          k;
    logic [15:0] exp_frame;
    logic        exp_last;
  } vec_rec_t;

  vec_rec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame k spikes on channel c iff floor((k+1)*I/16) > floor(k*I/16).
  function automatic logic [15:0] model_frame(input logic [15:0] vec, input int k);
    logic [15:0] f;
    f = '0;
    for (int c = 0; c < N_CH; c++) begin
      int i;
      i = int'(vec[c*INT_W +: INT_W]);
      if (((k + 1) * i) / STEPS > (k * i) / STEPS) begin
`ifdef SNN_ENC_BINARY_SPIKE_EN
        f[c*INT_W +: INT_W] = 4'd1;
`else
        f[c*INT_W +: INT_W] = 4'(i);
`endif
      end
    end
    return f;
  endfunction

  // Hand-written table entries are graded frames; unit spikes in the binary build.
  function automatic logic [15:0] exp_map(input logic [15:0] f);
    logic [15:0] m;
    m = f;
`ifdef SNN_ENC_BINARY_SPIKE_EN
    for (int c = 0; c < N_CH; c++)
      m[c*INT_W +: INT_W] = (f[c*INT_W +: INT_W] != 0) ? 4'd1 : 4'd0;
`endif
    return m;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic load(input logic [15:0] vec);
    int waited;
    waited = 0;
    while (!u_if.cfg_ready && waited < 32) begin
      @(negedge clk);
      waited++;
    end
    check("load_ready", 32'(u_if.cfg_ready), 32'd1);
    u_if.cfg_intensity = vec;
    u_if.cfg_valid     = 1'b1;
    @(negedge clk);
    u_if.cfg_valid = 1'b0;
    check("load_latency_valid", 32'(u_if.out_valid), 32'd1);
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      u_if.out_ready = 1'b1;
      @(negedge clk);
    end
    u_if.out_ready = 1'b0;
  endtask

  // Consume a whole window from frame 0 with random backpressure.
  task automatic drain(input logic [15:0] vec, input int pct);
    int          k;
    int          cyc;
    int          cnt [N_CH];
    logic [15:0] pf;
    logic        pl;
    logic        stalled;
    k = 0; cyc = 0; stalled = 1'b0; pf = '0; pl = 1'b0;
    for (int c = 0; c < N_CH; c++) cnt[c] = 0;
    while (k < STEPS && cyc < 400) begin
      check("drain_valid", 32'(u_if.out_valid), 32'd1);
      if (stalled) begin
        check("stall_frame", 32'(u_if.out_frame), 32'(pf));
        check("stall_last",  32'(u_if.out_last),  32'(pl));
      end
      check("frame", 32'(u_if.out_frame), 32'(model_frame(vec, k)));
      check("last",  32'(u_if.out_last),  32'(k == STEPS - 1));
      pf = u_if.out_frame;
      pl = u_if.out_last;
      u_if.out_ready = (int'($urandom_range(0, 99)) < pct);
      stalled = !u_if.out_ready;
      if (u_if.out_ready) begin
        for (int c = 0; c < N_CH; c++)
          if (u_if.out_frame[c*INT_W +: INT_W] != 0) cnt[c]++;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    u_if.out_ready = 1'b0;
    check("drain_timeout", 32'(k), 32'(STEPS));
    for (int c = 0; c < N_CH; c++)
      check("spike_count", 32'(cnt[c]), 32'(vec[c*INT_W +: INT_W]));
    check("busy_after",  32'(u_if.busy),      32'd0);
    check("ready_after", 32'(u_if.cfg_ready), 32'd1);
    check("valid_after", 32'(u_if.out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    u_if.cfg_valid     = 1'b0;
    u_if.cfg_intensity = '0;
    u_if.abort         = 1'b0;
    u_if.out_ready     = 1'b0;

    tbl[0] = '{16'hF800,  0, 16'h0000, 1'b0};
    tbl[1] = '{16'hF800,  1, 16'hF800, 1'b0};
    tbl[2] = '{16'hF800,  2, 16'hF000, 1'b0};
    tbl[3] = '{16'hF800, 15, 16'hF800, 1'b1};
    tbl[4] = '{16'h1234,  7, 16'h0204, 1'b0};
    tbl[5] = '{16'h0001, 14, 16'h0000, 1'b0};
    tbl[6] = '{16'h0001, 15, 16'h0001, 1'b1};
    tbl[7] = '{16'h5555,  3, 16'h5555, 1'b0};
    tbl[8] = '{16'h5555,  4, 16'h0000, 1'b0};
    tbl[9] = '{16'hFFFF,  5, 16'hFFFF, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_cfg_ready", 32'(u_if.cfg_ready), 32'd1);
    check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    check("rst_out_frame", 32'(u_if.out_frame), 32'd0);
    check("rst_out_last",  32'(u_if.out_last),  32'd0);
    check("rst_busy",      32'(u_if.busy),      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // abort while idle is ignored
    u_if.abort = 1'b1;
    @(negedge clk);
    u_if.abort = 1'b0;
    check("idle_abort_ready", 32'(u_if.cfg_ready), 32'd1);
    check("idle_abort_valid", 32'(u_if.out_valid), 32'd0);

    // Table: reach frame k, compare, then abort together with a transfer.
    foreach (tbl[i]) begin
      load(tbl[i].vec);
      advance(tbl[i].k);
      check("tbl_frame", 32'(u_if.out_frame), 32'(exp_map(tbl[i].exp_frame)));
      check("tbl_last",  32'(u_if.out_last),  32'(tbl[i].exp_last));
      u_if.abort     = 1'b1;
      u_if.out_ready = 1'b1;
      @(negedge clk);
      u_if.abort     = 1'b0;
      u_if.out_ready = 1'b0;
      check("tbl_abort_valid", 32'(u_if.out_valid), 32'd0);
      check("tbl_abort_ready", 32'(u_if.cfg_ready), 32'd1);
    end

    // Asynchronous reset at frame 5, then a fresh window.
    load(16'hF800);
    advance(5);
    check("pre_rst_frame", 32'(u_if.out_frame), 32'(model_frame(16'hF800, 5)));
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(u_if.out_valid), 32'd0);
    check("async_rst_ready", 32'(u_if.cfg_ready), 32'd1);
    check("async_rst_frame", 32'(u_if.out_frame), 32'd0);
    check("async_rst_busy",  32'(u_if.busy),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(16'h1234);
    drain(16'h1234, 100);

    load(16'hF800);
    drain(16'hF800, 100);

    load(16'h5555);
    drain(16'h5555, 50);

    // Abort at frame 7 while stalled.
    load(16'h1234);
    advance(7);
    u_if.abort = 1'b1;
    @(negedge clk);
    u_if.abort = 1'b0;
    check("abort7_valid", 32'(u_if.out_valid), 32'd0);
    check("abort7_ready", 32'(u_if.cfg_ready), 32'd1);
    check("abort7_busy",  32'(u_if.busy),      32'd0);
    load(16'h0001);
    drain(16'h0001, 100);

    // cfg_valid during the final transfer: one idle bubble, then the new window.
    load(16'h0001);
    advance(15);
    check("b2b_last", 32'(u_if.out_last), 32'd1);
    u_if.out_ready     = 1'b1;
    u_if.cfg_valid     = 1'b1;
    u_if.cfg_intensity = 16'hF800;
    @(negedge clk);
    u_if.out_ready = 1'b0;
    check("b2b_bubble_valid", 32'(u_if.out_valid), 32'd0);
    check("b2b_bubble_ready", 32'(u_if.cfg_ready), 32'd1);
    @(negedge clk);
    u_if.cfg_valid = 1'b0;
    check("b2b_new_valid", 32'(u_if.out_valid), 32'd1);
    drain(16'hF800, 100);

    repeat (6) begin
      v = 16'($urandom);
      load(v);
      drain(v, int'($urandom_range(30, 100)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
